temporizador_entrega: RTL and testbench
=======================================

TEMPORIZADOR_ENTREGA -- requirements
Module: temporizador_entrega

Interface
REQ-001 SHALL have parameter M, default 8: ticks in one delivery window; M even, M >= 4.
REQ-002 SHALL have parameter N, default 4: width of Q; 2^N >= M.
REQ-003 SHALL have port clock  in  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port zera_s  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port iniciar  in  1  start-delivery request, sampled each cycle.
REQ-006 SHALL have port tick  in  1  time-base enable, one-cycle pulses.
REQ-007 SHALL have port entregue  in  1  delivery-completed request.
REQ-008 SHALL have port Q  out  N  elapsed ticks of current delivery.
REQ-009 SHALL have port alerta  out  1  high while in ALERTA.
REQ-010 SHALL have port sucesso  out  1  high only in SUCESSO.
REQ-011 SHALL have port falha  out  1  high only in FALHA.
REQ-012 SHALL have port ocupado  out  1  high in CONTANDO or ALERTA.
REQ-013 SHALL have port pontos  out  8  score.
REQ-014 SHALL have port estado  out  3  current state encoding, for debug.

Function
REQ-015 SHALL implement a Moore FSM with states OCIOSO=0, CONTANDO=1, ALERTA=2, SUCESSO=3, FALHA=4; codes 5-7 SHALL go to OCIOSO on the next edge.
REQ-016 SHALL define meio = (Q == M/2-1) and fim = (Q == M-1) combinationally from registered Q.
REQ-017 OCIOSO: iniciar=1 -> CONTANDO next edge; Q held at 0; tick and entregue ignored.
REQ-018 CONTANDO: entregue=1 -> SUCESSO; else meio=1 -> ALERTA; else stay.
REQ-019 ALERTA: entregue=1 -> SUCESSO; else fim=1 -> FALHA; else stay.
REQ-020 entregue SHALL have priority over meio or fim in the same cycle.
REQ-021 SUCESSO and FALHA SHALL each last exactly one cycle, then go to OCIOSO unconditionally.
REQ-022 In CONTANDO or ALERTA, tick=1 and Q != M-1 SHALL increment Q on that edge.
REQ-023 Q SHALL saturate at M-1 and never wrap.
REQ-024 Q SHALL hold its value in SUCESSO and FALHA.
REQ-025 Q SHALL clear to 0 on the edge that enters OCIOSO.
REQ-026 iniciar SHALL be ignored outside OCIOSO; it is not queued.
REQ-027 pontos SHALL update on the edge entering SUCESSO, so the new value is visible while sucesso=1.
REQ-028 pontos SHALL saturate at 255.
REQ-029 FALHA SHALL leave pontos unchanged.
REQ-030 alerta, sucesso, falha and ocupado SHALL be pure decodes of the state register, with no combinational input-to-output path.

Reset
REQ-031 zera_s=1 SHALL, at the next edge, set estado=OCIOSO, Q=0 and pontos=0.
REQ-032 zera_s SHALL override all other inputs in that cycle.
REQ-033 zera_s asserted mid-delivery SHALL abort without producing a sucesso or falha pulse.
REQ-034 After reset, every output SHALL be 0.

Configuration
REQ-035 Macro BONUS_RAPIDO_EN defined: entering SUCESSO from CONTANDO SHALL add 2 to pontos (saturating at 255), and entering SUCESSO from ALERTA SHALL add 1.
REQ-036 Macro BONUS_RAPIDO_EN undefined: every entry to SUCESSO SHALL add 1 to pontos.

Verification (M=8, N=4)
REQ-037 Reset: zera_s high 2 cycles -> Q=0, pontos=0, estado=0, all flags 0.
REQ-038 Fast delivery: iniciar, 2 ticks, entregue -> sucesso high exactly 1 cycle, pontos=1 (2 with BONUS_RAPIDO_EN), then estado=0, Q=0.
REQ-039 Timeout: iniciar, 12 ticks, no entregue -> alerta rises the edge after Q=3, Q stops at 7, falha high exactly 1 cycle, pontos unchanged, then Q=0.
REQ-040 Simultaneous event: in ALERTA with Q=7 and entregue=1 -> SUCESSO, falha never asserted, pontos +1; iniciar pulsed during CONTANDO -> no effect.
REQ-041 Reset mid-ALERTA with Q=5 -> next edge estado=0, Q=0, pontos=0, no sucesso or falha pulse.
REQ-042 Saturation: 300 fast deliveries -> pontos=255 and stays at 255.

Source files
------------

// File: rtl/temporizador_entrega.sv
// Delivery window timer: Moore FSM with tick counter and saturating score.
// Optional macro BONUS_RAPIDO_EN: deliveries completed before the alert earn 2 points.
module temporizador_entrega #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         iniciar,
    input  logic         tick,
    input  logic         entregue,
    output logic [N-1:0] Q,
    output logic         alerta,
    output logic         sucesso,
    output logic         falha,
    output logic         ocupado,
    output logic [7:0]   pontos,
    output logic [2:0]   estado
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        CONTANDO = 3'd1,
        ALERTA   = 3'd2,
        SUCESSO  = 3'd3,
        FALHA    = 3'd4
    } estado_t;

    localparam logic [N-1:0] L_MEIO = N'(M / 2 - 1);
    localparam logic [N-1:0] L_FIM  = N'(M - 1);

    estado_t        r_estado;
    estado_t        w_prox;
    logic [N-1:0]   r_q;
    logic [7:0]     r_pontos;
    logic           w_meio;
    logic           w_fim;
    logic           w_ativo;
    logic           w_q_inc;
    logic           w_entra_suc;
    logic [8:0]     w_ganho;
    logic [8:0]     w_soma;
    logic [7:0]     w_pontos_sat;

    assign w_meio  = (r_q == L_MEIO);
    assign w_fim   = (r_q == L_FIM);
    assign w_ativo = (r_estado == CONTANDO) || (r_estado == ALERTA);
    assign w_q_inc = w_ativo && tick && !w_fim;

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (iniciar) w_prox = CONTANDO;
            end
            CONTANDO: begin
                if (entregue)    w_prox = SUCESSO;
                else if (w_meio) w_prox = ALERTA;
            end
            ALERTA: begin
                if (entregue)   w_prox = SUCESSO;
                else if (w_fim) w_prox = FALHA;
            end
            SUCESSO: w_prox = OCIOSO;
            FALHA:   w_prox = OCIOSO;
            default: w_prox = OCIOSO;
        endcase
    end

    assign w_entra_suc = w_ativo && (w_prox == SUCESSO);

`ifdef BONUS_RAPIDO_EN
    assign w_ganho = (r_estado == CONTANDO) ? 9'd2 : 9'd1;
`else
    assign w_ganho = 9'd1;
`endif

    assign w_soma       = {1'b0, r_pontos} + w_ganho;
    assign w_pontos_sat = w_soma[8] ? 8'hFF : w_soma[7:0];

    always_ff @(posedge clock) begin
        if (zera_s) begin
            r_estado <= OCIOSO;
            r_q      <= '0;
            r_pontos <= '0;
        end else begin
            r_estado <= w_prox;
            // Q is cleared on every entry to idle, held in the result states
            if (w_prox == OCIOSO) r_q <= '0;
            else if (w_q_inc)     r_q <= r_q + 1'b1;
            if (w_entra_suc) r_pontos <= w_pontos_sat;
        end
    end

    assign Q       = r_q;
    assign pontos  = r_pontos;
    assign estado  = r_estado;
    assign alerta  = (r_estado == ALERTA);
    assign sucesso = (r_estado == SUCESSO);
    assign falha   = (r_estado == FALHA);
    assign ocupado = w_ativo;

endmodule

// File: tb/tb_temporizador_entrega.sv
// Bench for temporizador_entrega: directed scenarios plus random traffic
// checked every cycle against a delivery-level reference model.
module tb_temporizador_entrega;

    localparam int M = 8;
    localparam int N = 4;

`ifdef BONUS_RAPIDO_EN
    localparam int GANHO_RAPIDO = 2;
`else
    localparam int GANHO_RAPIDO = 1;
`endif

    logic         clock = 1'b0;
    logic         zera_s = 1'b1;
    logic         iniciar = 1'b0;
    logic         tick = 1'b0;
    logic         entregue = 1'b0;
    logic [N-1:0] Q;
    logic         alerta, sucesso, falha, ocupado;
    logic [7:0]   pontos;
    logic [2:0]   estado;

    temporizador_entrega #(.M(M), .N(N)) dut (
        .clock    (clock),
        .zera_s   (zera_s),
        .iniciar  (iniciar),
        .tick     (tick),
        .entregue (entregue),
        .Q        (Q),
        .alerta   (alerta),
        .sucesso  (sucesso),
        .falha    (falha),
        .ocupado  (ocupado),
        .pontos   (pontos),
        .estado   (estado)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference: a delivery is in progress or not, warned or not,
    // and a one-cycle outcome (0 none, 1 delivered, 2 timed out).
    bit m_busy, m_warn;
    int m_res, m_el, m_sc;
    int n_suc, n_fal, maxq;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit rst, input bit ini, input bit tk, input bit ent);
        int nel;
        if (rst) begin
            m_busy = 0; m_warn = 0; m_res = 0; m_el = 0; m_sc = 0;
        end else if (m_res != 0) begin
            m_res = 0; m_el = 0;
        end else if (!m_busy) begin
            if (ini) m_busy = 1;
            m_el = 0;
        end else begin
            nel = (tk && m_el < M - 1) ? m_el + 1 : m_el;
            if (ent) begin
                m_sc += m_warn ? 1 : GANHO_RAPIDO;
                if (m_sc > 255) m_sc = 255;
                m_res = 1; m_busy = 0; m_warn = 0;
            end else if (!m_warn && m_el == M / 2 - 1) begin
                m_warn = 1;
            end else if (m_warn && m_el == M - 1) begin
                m_res = 2; m_busy = 0; m_warn = 0;
            end
            m_el = nel;
        end
    endtask

    task automatic step(input bit rst, input bit ini, input bit tk, input bit ent);
        int e;
        zera_s = rst; iniciar = ini; tick = tk; entregue = ent;
        @(posedge clock);
        model(rst, ini, tk, ent);
        #1;
        e = (m_res == 1) ? 3 : (m_res == 2) ? 4 : !m_busy ? 0 : m_warn ? 2 : 1;
        chk("Q", int'(Q), m_el);
        chk("estado", int'(estado), e);
        chk("pontos", int'(pontos), m_sc);
        chk("alerta", int'(alerta), int'(e == 2));
        chk("sucesso", int'(sucesso), int'(e == 3));
        chk("falha", int'(falha), int'(e == 4));
        chk("ocupado", int'(ocupado), int'(e == 1 || e == 2));
        n_suc += int'(sucesso);
        n_fal += int'(falha);
        if (int'(Q) > maxq) maxq = int'(Q);
    endtask

    initial begin
        int p1;
        // Reset held two cycles
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        chk("rst_Q", int'(Q), 0);
        chk("rst_pontos", int'(pontos), 0);
        chk("rst_flags", int'({alerta, sucesso, falha, ocupado, estado}), 0);

        // Fast delivery
        n_suc = 0;
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("fast_pontos", int'(pontos), GANHO_RAPIDO);
        step(0, 0, 0, 0);
        chk("fast_suc_pulses", n_suc, 1);
        chk("fast_estado", int'(estado), 0);
        chk("fast_Q", int'(Q), 0);
        p1 = GANHO_RAPIDO;

        // Timeout
        n_fal = 0; maxq = 0;
        step(0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
        chk("to_falha_pulses", n_fal, 1);
        chk("to_maxq", maxq, M - 1);
        chk("to_pontos", int'(pontos), p1);
        chk("to_Q", int'(Q), 0);

        // Entregue at Q=M-1 in ALERTA; iniciar pulsed while counting
        n_fal = 0;
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        chk("sim_alerta", int'(estado), 2);
        chk("sim_Q", int'(Q), M - 1);
        step(0, 0, 0, 1);
        chk("sim_estado", int'(estado), 3);
        chk("sim_pontos", int'(pontos), p1 + 1);
        step(0, 0, 0, 0);
        chk("sim_no_falha", n_fal, 0);

        // Reset mid-ALERTA with Q=5
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        chk("mid_estado", int'(estado), 2);
        chk("mid_Q", int'(Q), 5);
        n_suc = 0; n_fal = 0;
        step(1, 0, 1, 1);
        chk("mid_rst_estado", int'(estado), 0);
        chk("mid_rst_Q", int'(Q), 0);
        chk("mid_rst_pontos", int'(pontos), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("mid_no_pulse", n_suc + n_fal, 0);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        chk("sat_pontos", int'(pontos), 255);
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        chk("sat_hold", int'(pontos), 255);

        // Random traffic
        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
